seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Parametrised multiplexed seven-segment display controller: scans DIGITS common-anode digits from a double-buffered hex value and adds decimal points, leading-zero suppression, per-digit blink and 16-level PWM brightness. It sits between the result path (e.g. the BFLOAT16 FMA result) and the board's segment/anode pins. It is the drop-in successor to the fixed 4-digit scanner. New values are latched by a load strobe and applied only at frame boundaries, so the display never tears.

## Interface
- DIGITS, 4: number of digits scanned; legal range 1..8.
- REFRESH_CYCLES, 100_000: clock cycles per digit slot (1 ms at 100 MHz); must be ≥ 16.
- BLINK_TICKS, 250: digit slots per blink half-period; must be ≥ 1.
- clock_100Mhz  in  1  system clock; all state on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- load  in  1  single-cycle strobe; captures value/dp into the pending buffer.
- value  in  4*DIGITS  hex nibbles; digit i = value[4i+3:4i]; digit 0 is rightmost.
- dp  in  DIGITS  decimal point request per digit; 1 = lit.
- blank_lz  in  1  1 = suppress leading zeros.
- blink_mask  in  DIGITS  1 = digit blinks; sampled live, not buffered.
- brightness  in  4  PWM duty: (brightness+1)/16.
- LED_out  out  [0:6]  segments a..g, active-low; LED_out[0]=a.
- dp_out  out  1  decimal point segment, active-low.
- Anode_Activate  out  DIGITS  digit enables, active-low; at most one bit low.
- frame_done  out  1  one-cycle pulse at the end of each full scan.

## Operation
- Counters:
  - slot_timer runs 0..REFRESH_CYCLES-1. Slot end is slot_timer == REFRESH_CYCLES-1.
  - At slot end, digit_select advances 0→1→…→DIGITS-1→0 and wraps modulo DIGITS, not modulo a power of two.
  - pwm_cnt is a free-running 4-bit counter that increments every cycle.
- Frame boundary = slot end while digit_select == DIGITS-1.
- Buffering:
  - load writes the pending value/dp and sets pend_valid.
  - At the frame boundary, if pend_valid, then active ← pending and pend_valid ← 0.
  - If load coincides with the frame boundary, the newly loaded data goes straight into active.
  - A second load before the boundary overwrites pending; last write wins.
- Leading-zero suppression (blank_lz=1):
  - Scanning from digit DIGITS-1 down, a digit is blanked while its nibble is 0 and its dp is 0.
  - The first non-zero nibble or set dp ends suppression.
  - Digit 0 is never suppressed.
- Blink:
  - blink_cnt counts slot ends. At BLINK_TICKS-1 it clears and blink_phase toggles.
  - While blink_phase=1, digits with blink_mask set are blanked.
- Anode drive: Anode_Activate bit digit_select is low only if the digit is not blanked and pwm_cnt ≤ brightness. Otherwise all bits are high.
- Segment decode (a..g, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- Blanked digit: LED_out=1111111 and dp_out=1, in addition to the anode being off.

## Timing
- Reset values:
  - Outputs: LED_out=1111111, dp_out=1, Anode_Activate=all 1s, frame_done=0.
  - Internal state: slot_timer=0, digit_select=0, pwm_cnt=0, blink_cnt=0, blink_phase=0, active=0, pending=0, pend_valid=0.
- All outputs are registered and lag the internal counters by one cycle.
- First output cycle after reset release displays digit 0 of value 0 with the anode on, because pwm_cnt=0 ≤ brightness.
- frame_done is asserted on the cycle after the frame boundary, for one cycle. Period = DIGITS*REFRESH_CYCLES cycles.
- Load latency:
  - Data becomes visible on digit 0 in the output cycle after the next frame boundary.
  - Worst case is DIGITS*REFRESH_CYCLES+1 cycles.
- blink_mask, blank_lz and brightness take effect one cycle after they change, with no buffering.
- Reset asserted mid-frame clears everything immediately (asynchronous). Pending data is discarded.
- brightness=15 gives a 100 % duty cycle, so the anode stays continuously low for the whole slot.

## Test plan
- Reset, then load value=16'h12AF (DIGITS=4, REFRESH_CYCLES=16) → after the boundary:
  - digit 0 shows F (0111000, Anode=1110);
  - digit 1 shows A, digit 2 shows 2, digit 3 shows 1 (0010010, 1001111);
  - frame_done pulses every 64 cycles.
- Two loads in one frame (16'h1111 then 16'h2222) → 1111 is never displayed; 2222 appears on the next frame; no mixed frame.
- Load asserted exactly on the frame-boundary cycle → new value shown starting with the next frame's digit 0.
- blank_lz=1:
  - value=16'h0030, dp=0 → digits 3 and 2 have all anodes high, digit 1 shows 3, digit 0 shows 0.
  - value=0 → only digit 0 lit.
  - dp=4'b0100 → digit 2 is lit as 0 with dp_out=0.
- brightness=3 → per slot, the anode is low for 4 of every 16 cycles. brightness=15 → the anode is low for the whole slot.
- BLINK_TICKS=2, blink_mask=4'b0001 → digit 0 is blanked in alternate 2-slot windows; other digits are unaffected.
- Reset asserted mid-slot → all outputs reach their reset values within the same cycle.
- DIGITS=6 → digit_select wraps 5→0.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
//
// Multiplexed seven-segment display scanner for DIGITS common-anode digits.
// A hex value and its decimal points are double-buffered: a load strobe fills
// the pending buffer and the active buffer is only replaced at the end of a
// full scan, so a frame never shows a mix of old and new digits. On top of the
// plain scan it adds leading-zero suppression, per-digit blink and a 16-level
// PWM brightness control.
//
// Parameters
//   DIGITS         number of digits scanned (1..8)
//   REFRESH_CYCLES clock cycles per digit slot (>= 16)
//   BLINK_TICKS    digit slots per blink half-period (>= 1)
//
// Ports
//   clock_100Mhz   system clock, all state on the rising edge
//   reset          asynchronous active-high reset, clears all state
//   load           single-cycle strobe, captures value/dp into pending buffer
//   value          hex nibbles, digit i = value[4i+3:4i], digit 0 rightmost
//   dp             per-digit decimal point request (1 = lit)
//   blank_lz       1 = suppress leading zeros
//   blink_mask     per-digit blink enable, used live (not buffered)
//   brightness     PWM duty (brightness+1)/16
//   LED_out        segments a..g, active-low, LED_out[0] = a
//   dp_out         decimal point segment, active-low
//   Anode_Activate digit enables, active-low, at most one bit low
//   frame_done     one-cycle pulse the cycle after each full scan ends
// -----------------------------------------------------------------------------
module seg7_scan_ctrl #(
  parameter int DIGITS         = 4,
  parameter int REFRESH_CYCLES = 100_000,
  parameter int BLINK_TICKS    = 250
) (
  input  logic                  clock_100Mhz,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic [3:0]            brightness,
  output logic [0:6]            LED_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     Anode_Activate,
  output logic                  frame_done
);

  localparam int SLOT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int DSEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BLNK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_CYCLES - 1);
  localparam logic [DSEL_W-1:0] DSEL_LAST = DSEL_W'(DIGITS - 1);
  localparam logic [BLNK_W-1:0] BLNK_LAST = BLNK_W'(BLINK_TICKS - 1);

  // Scan counters
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [DSEL_W-1:0]   dsel_q, dsel_d;
  logic [3:0]          pwm_q, pwm_d;
  logic [BLNK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;

  // Display buffers
  logic [4*DIGITS-1:0] act_val_q, act_val_d;
  logic [DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_valid_q, pend_valid_d;

  // Registered outputs
  logic [0:6]          led_q, led_d;
  logic                dp_out_q, dp_out_d;
  logic [DIGITS-1:0]   anode_q, anode_d;
  logic                frame_done_q, frame_done_d;

  logic                slot_end;
  logic                frame_end;

  logic [3:0]          nib [DIGITS];
  logic [DIGITS-1:0]   supp;

  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_supp;
  logic                cur_mask;
  logic                blanked;
  logic                lit;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign slot_end  = (slot_q == SLOT_LAST);
  assign frame_end = slot_end && (dsel_q == DSEL_LAST);

  // Leading-zero suppression chain, evaluated from the most significant digit
  // down. A digit stays suppressed only while every digit above it was too.
  // Digit 0 is always shown so an all-zero value still reads "0".
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign nib[gi] = act_val_q[4*gi +: 4];
    if (gi == 0) begin : g_lsd
      assign supp[gi] = 1'b0;
    end else if (gi == DIGITS - 1) begin : g_msd
      assign supp[gi] = blank_lz && (nib[gi] == 4'h0) && !act_dp_q[gi];
    end else begin : g_mid
      assign supp[gi] = supp[gi+1] && (nib[gi] == 4'h0) && !act_dp_q[gi];
    end
    assign anode_d[gi] = !(lit && (dsel_q == DSEL_W'(gi)));
  end

  // Mux the currently scanned digit out of the per-digit vectors.
  always_comb begin
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    cur_supp = 1'b0;
    cur_mask = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dsel_q == DSEL_W'(i)) begin
        cur_nib  = nib[i];
        cur_dp   = act_dp_q[i];
        cur_supp = supp[i];
        cur_mask = blink_mask[i];
      end
    end
  end

  assign blanked = cur_supp || (blink_phase_q && cur_mask);
  assign lit     = !blanked && (pwm_q <= brightness);

  // Segment drive stays decoded during the PWM off-time; only a blanked digit
  // forces the segments dark.
  always_comb begin
    led_d        = blanked ? 7'b1111111 : seg_decode(cur_nib);
    dp_out_d     = blanked || !cur_dp;
    frame_done_d = frame_end;
  end

  // Counter next-state
  always_comb begin
    slot_d        = slot_end ? '0 : slot_q + SLOT_W'(1);
    dsel_d        = dsel_q;
    pwm_d         = pwm_q + 4'd1;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (slot_end) begin
      // Explicit wrap so non-power-of-two digit counts scan correctly.
      dsel_d = (dsel_q == DSEL_LAST) ? '0 : dsel_q + DSEL_W'(1);
      if (blink_cnt_q == BLNK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLNK_W'(1);
      end
    end
  end

  // Double buffer: pending is filled by load, promoted only at the end of a
  // frame. A load on the boundary cycle bypasses pending so it is not delayed
  // by a whole extra frame.
  always_comb begin
    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp;
      pend_valid_d = 1'b1;
    end
    if (frame_end) begin
      if (load) begin
        act_val_d = value;
        act_dp_d  = dp;
      end else if (pend_valid_q) begin
        act_val_d = pend_val_q;
        act_dp_d  = pend_dp_q;
      end
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      slot_q        <= '0;
      dsel_q        <= '0;
      pwm_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      act_val_q     <= '0;
      act_dp_q      <= '0;
      pend_val_q    <= '0;
      pend_dp_q     <= '0;
      pend_valid_q  <= 1'b0;
      led_q         <= 7'b1111111;
      dp_out_q      <= 1'b1;
      anode_q       <= '1;
      frame_done_q  <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      dsel_q        <= dsel_d;
      pwm_q         <= pwm_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      act_val_q     <= act_val_d;
      act_dp_q      <= act_dp_d;
      pend_val_q    <= pend_val_d;
      pend_dp_q     <= pend_dp_d;
      pend_valid_q  <= pend_valid_d;
      led_q         <= led_d;
      dp_out_q      <= dp_out_d;
      anode_q       <= anode_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign LED_out        = led_q;
  assign dp_out         = dp_out_q;
  assign Anode_Activate = anode_q;
  assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_ctrl
//
// Bench for seg7_scan_ctrl. Main instance: DIGITS=4, REFRESH_CYCLES=16,
// BLINK_TICKS=2. A second instance with DIGITS=6 checks the non-power-of-two
// digit wrap. Expected outputs come from a behavioural model that derives
// slot, digit, PWM step and blink phase arithmetically from the cycle count
// since reset, and applies the buffering rules at frame boundaries.
// -----------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

  localparam int D  = 4;
  localparam int R  = 16;
  localparam int BT = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp = 4'h0;
  logic        blank_lz = 1'b0;
  logic [3:0]  blink_mask = 4'h0;
  logic [3:0]  brightness = 4'hF;
  logic [0:6]  LED_out;
  logic        dp_out;
  logic [3:0]  Anode_Activate;
  logic        frame_done;

  logic [0:6]  led6;
  logic        dp6;
  logic [5:0]  an6;
  logic        fd6;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  seg7_scan_ctrl #(.DIGITS(D), .REFRESH_CYCLES(R), .BLINK_TICKS(BT)) u_dut (
    .clock_100Mhz   (clk),
    .reset          (reset),
    .load           (load),
    .value          (value),
    .dp             (dp),
    .blank_lz       (blank_lz),
    .blink_mask     (blink_mask),
    .brightness     (brightness),
    .LED_out        (LED_out),
    .dp_out         (dp_out),
    .Anode_Activate (Anode_Activate),
    .frame_done     (frame_done)
  );

  seg7_scan_ctrl #(.DIGITS(6), .REFRESH_CYCLES(R), .BLINK_TICKS(250)) u_dut6 (
    .clock_100Mhz   (clk),
    .reset          (reset),
    .load           (1'b0),
    .value          (24'h0),
    .dp             (6'h0),
    .blank_lz       (1'b0),
    .blink_mask     (6'h0),
    .brightness     (4'hF),
    .LED_out        (led6),
    .dp_out         (dp6),
    .Anode_Activate (an6),
    .frame_done     (fd6)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int          k;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_act_dp, m_pend_dp;
  logic        m_pv;
  logic [11:0] exp_pack;   // {led[6:0], dp_out, anode[3:0]}
  logic        exp_fd;

  function automatic bit is_boundary(input int kk);
    return ((kk % R) == R - 1) && (((kk / R) % D) == D - 1);
  endfunction

  function automatic logic [11:0] model_out(input int kk, input logic [15:0] av,
                                            input logic [3:0] adp, input logic lz,
                                            input logic [3:0] mask, input logic [3:0] br);
    int         slot_idx, dig, pwm;
    bit         phase, blank, leading;
    logic [3:0] nb;
    logic [6:0] led;
    logic       dpo;
    logic [3:0] an;
    slot_idx = kk / R;
    dig      = slot_idx % D;
    pwm      = kk % 16;
    phase    = ((slot_idx / BT) % 2) == 1;
    leading  = lz;
    blank    = 1'b0;
    for (int i = D - 1; i >= 0; i--) begin
      nb = av[4*i +: 4];
      if (i == 0 || nb != 4'h0 || adp[i]) leading = 1'b0;
      if (i == dig) blank = leading;
    end
    blank = blank || (phase && mask[dig]);
    nb    = av[4*dig +: 4];
    led   = blank ? 7'b1111111 : seg_tab[nb];
    dpo   = blank ? 1'b1 : !adp[dig];
    an    = 4'hF;
    if (!blank && pwm <= int'(br)) an[dig] = 1'b0;
    return {led, dpo, an};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      k         <= 0;
      m_act     <= '0;
      m_act_dp  <= '0;
      m_pend    <= '0;
      m_pend_dp <= '0;
      m_pv      <= 1'b0;
      exp_pack  <= {7'b1111111, 1'b1, 4'hF};
      exp_fd    <= 1'b0;
    end else begin
      exp_pack <= model_out(k, m_act, m_act_dp, blank_lz, blink_mask, brightness);
      exp_fd   <= is_boundary(k);
      if (is_boundary(k)) begin
        if (load) begin
          m_act    <= value;
          m_act_dp <= dp;
        end else if (m_pv) begin
          m_act    <= m_pend;
          m_act_dp <= m_pend_dp;
        end
        m_pv <= 1'b0;
      end else if (load) begin
        m_pend    <= value;
        m_pend_dp <= dp;
        m_pv      <= 1'b1;
      end
      k <= k + 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    load  = 1'b1;
    value = v;
    dp    = d;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_fd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_fd6(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (fd6 === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (LED_out !== 7'b1111111) begin n_fail++; $display("FAIL reset_led: got %b expected 1111111", LED_out); end
    n_checks++;
    if (dp_out !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b expected 1", dp_out); end
    n_checks++;
    if (Anode_Activate !== 4'hF) begin n_fail++; $display("FAIL reset_anode: got %b expected 1111", Anode_Activate); end
    n_checks++;
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b expected 0", frame_done); end
    n_checks++;
    if (an6 !== 6'h3F) begin n_fail++; $display("FAIL reset_anode6: got %b expected 111111", an6); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (LED_out !== 7'b0000001) begin n_fail++; $display("FAIL first_led: got %b expected 0000001", LED_out); end
    n_checks++;
    if (Anode_Activate !== 4'b1110) begin n_fail++; $display("FAIL first_anode: got %b expected 1110", Anode_Activate); end
    $display("test_reset done: led=%b anode=%b", LED_out, Anode_Activate);
  endtask

  task automatic test_decode();
    logic [6:0] e [4];
    logic [3:0] ea;
    bit ok;
    int t0;
    e[0] = 7'b0111000; e[1] = 7'b0001000; e[2] = 7'b0010010; e[3] = 7'b1001111;
    brightness = 4'hF; blank_lz = 1'b0; blink_mask = 4'h0;
    do_load(16'h12AF, 4'h0);
    wait_fd(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL decode_sync: got no frame_done expected a pulse"); end
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) @(negedge clk); else repeat (R) @(negedge clk);
      ea = ~(4'b0001 << i);
      n_checks++;
      if (LED_out !== e[i]) begin n_fail++; $display("FAIL decode_led%0d: got %b expected %b", i, LED_out, e[i]); end
      n_checks++;
      if (Anode_Activate !== ea) begin n_fail++; $display("FAIL decode_anode%0d: got %b expected %b", i, Anode_Activate, ea); end
      n_checks++;
      if (dp_out !== 1'b1) begin n_fail++; $display("FAIL decode_dp%0d: got %b expected 1", i, dp_out); end
    end
    wait_fd(ok);
    n_checks++;
    if (!ok || (cyc - t0) != D * R) begin
      n_fail++; $display("FAIL frame_period: got %0d expected %0d", cyc - t0, D * R);
    end
    $display("test_decode done: period=%0d", cyc - t0);
  endtask

  task automatic test_double_load();
    bit ok;
    wait_fd(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL dbl_sync: got no frame_done expected a pulse"); end
    do_load(16'h1111, 4'h0);
    repeat (5) @(negedge clk);
    do_load(16'h2222, 4'h0);
    wait_fd(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL dbl_sync2: got no frame_done expected a pulse"); end
    for (int c = 0; c < D * R; c++) begin
      @(negedge clk);
      n_checks++;
      if (LED_out !== 7'b0010010) begin n_fail++; $display("FAIL dbl_led c%0d: got %b expected 0010010", c, LED_out); end
    end
    $display("test_double_load done");
  endtask

  task automatic test_load_on_boundary();
    bit ok;
    logic [3:0] ea;
    wait_fd(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bnd_sync: got no frame_done expected a pulse"); end
    repeat (D * R - 1) @(negedge clk);
    load = 1'b1; value = 16'h3333; dp = 4'h0;
    @(negedge clk);
    load = 1'b0;
    n_checks++;
    if (frame_done !== 1'b1) begin n_fail++; $display("FAIL bnd_fd: got %b expected 1", frame_done); end
    for (int i = 0; i < 4; i++) begin
      if (i == 0) @(negedge clk); else repeat (R) @(negedge clk);
      ea = ~(4'b0001 << i);
      n_checks++;
      if (LED_out !== 7'b0000110) begin n_fail++; $display("FAIL bnd_led%0d: got %b expected 0000110", i, LED_out); end
      n_checks++;
      if (Anode_Activate !== ea) begin n_fail++; $display("FAIL bnd_anode%0d: got %b expected %b", i, Anode_Activate, ea); end
    end
    $display("test_load_on_boundary done");
  endtask

  task automatic test_lz();
    logic [15:0] vals [3];
    logic [3:0]  dps  [3];
    logic [3:0]  an_e [3][4];
    logic [6:0]  led_e [3][4];
    logic        dp_e [3][4];
    bit ok;
    vals[0] = 16'h0030; dps[0] = 4'b0000;
    vals[1] = 16'h0000; dps[1] = 4'b0000;
    vals[2] = 16'h0000; dps[2] = 4'b0100;
    an_e[0] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    led_e[0] = '{7'b0000001, 7'b0000110, 7'b1111111, 7'b1111111};
    dp_e[0] = '{1'b1, 1'b1, 1'b1, 1'b1};
    an_e[1] = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
    led_e[1] = '{7'b0000001, 7'b1111111, 7'b1111111, 7'b1111111};
    dp_e[1] = '{1'b1, 1'b1, 1'b1, 1'b1};
    an_e[2] = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};
    led_e[2] = '{7'b0000001, 7'b0000001, 7'b0000001, 7'b1111111};
    dp_e[2] = '{1'b1, 1'b1, 1'b0, 1'b1};
    blank_lz = 1'b1;
    for (int s = 0; s < 3; s++) begin
      do_load(vals[s], dps[s]);
      wait_fd(ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL lz_sync s%0d: got no frame_done expected a pulse", s); end
      for (int i = 0; i < 4; i++) begin
        if (i == 0) @(negedge clk); else repeat (R) @(negedge clk);
        n_checks++;
        if (Anode_Activate !== an_e[s][i]) begin n_fail++; $display("FAIL lz_anode s%0d d%0d: got %b expected %b", s, i, Anode_Activate, an_e[s][i]); end
        n_checks++;
        if (LED_out !== led_e[s][i]) begin n_fail++; $display("FAIL lz_led s%0d d%0d: got %b expected %b", s, i, LED_out, led_e[s][i]); end
        n_checks++;
        if (dp_out !== dp_e[s][i]) begin n_fail++; $display("FAIL lz_dp s%0d d%0d: got %b expected %b", s, i, dp_out, dp_e[s][i]); end
      end
      $display("test_lz scenario %0d value=%h dp=%b done", s, vals[s], dps[s]);
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_pwm();
    bit ok;
    int lows, others;
    brightness = 4'd3;
    do_load(16'h8888, 4'h0);
    wait_fd(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL pwm_sync: got no frame_done expected a pulse"); end
    lows = 0; others = 0;
    for (int c = 0; c < R; c++) begin
      @(negedge clk);
      if (Anode_Activate[0] == 1'b0) lows++;
      if (Anode_Activate[3:1] != 3'b111) others++;
    end
    n_checks++;
    if (lows != 4) begin n_fail++; $display("FAIL pwm_b3_low: got %0d cycles expected 4", lows); end
    n_checks++;
    if (others != 0) begin n_fail++; $display("FAIL pwm_b3_other: got %0d cycles expected 0", others); end
    brightness = 4'hF;
    lows = 0;
    for (int c = 0; c < R; c++) begin
      @(negedge clk);
      if (Anode_Activate[1] == 1'b0) lows++;
    end
    n_checks++;
    if (lows != R) begin n_fail++; $display("FAIL pwm_b15_low: got %0d cycles expected %0d", lows, R); end
    $display("test_pwm done");
  endtask

  task automatic test_blink();
    int lows [4];
    for (int i = 0; i < 4; i++) lows[i] = 0;
    brightness = 4'hF;
    blink_mask = 4'b1111;
    for (int c = 0; c < 3 * D * R; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (Anode_Activate[i] == 1'b0) lows[i]++;
      n_checks++;
      if (LED_out !== exp_pack[11:5]) begin n_fail++; $display("FAIL blink_led c%0d: got %b expected %b", c, LED_out, exp_pack[11:5]); end
      n_checks++;
      if (Anode_Activate !== exp_pack[3:0]) begin n_fail++; $display("FAIL blink_anode c%0d: got %b expected %b", c, Anode_Activate, exp_pack[3:0]); end
    end
    // Slots 2,3 of every frame fall in blink phase 1 with BLINK_TICKS=2.
    n_checks++;
    if (lows[0] != 3 * R) begin n_fail++; $display("FAIL blink_d0: got %0d lit cycles expected %0d", lows[0], 3 * R); end
    n_checks++;
    if (lows[1] != 3 * R) begin n_fail++; $display("FAIL blink_d1: got %0d lit cycles expected %0d", lows[1], 3 * R); end
    n_checks++;
    if (lows[2] != 0) begin n_fail++; $display("FAIL blink_d2: got %0d lit cycles expected 0", lows[2]); end
    n_checks++;
    if (lows[3] != 0) begin n_fail++; $display("FAIL blink_d3: got %0d lit cycles expected 0", lows[3]); end
    blink_mask = 4'h0;
    $display("test_blink done: lit=%0d/%0d/%0d/%0d", lows[0], lows[1], lows[2], lows[3]);
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      n_checks++;
      if (LED_out !== exp_pack[11:5]) begin n_fail++; $display("FAIL rnd_led c%0d: got %b expected %b", c, LED_out, exp_pack[11:5]); end
      n_checks++;
      if (dp_out !== exp_pack[4]) begin n_fail++; $display("FAIL rnd_dp c%0d: got %b expected %b", c, dp_out, exp_pack[4]); end
      n_checks++;
      if (Anode_Activate !== exp_pack[3:0]) begin n_fail++; $display("FAIL rnd_anode c%0d: got %b expected %b", c, Anode_Activate, exp_pack[3:0]); end
      n_checks++;
      if (frame_done !== exp_fd) begin n_fail++; $display("FAIL rnd_fd c%0d: got %b expected %b", c, frame_done, exp_fd); end
      load  = ($urandom_range(0, 29) == 0);
      value = 16'($urandom);
      dp    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 15) == 0) blank_lz   = 1'($urandom);
      if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom);
      if ($urandom_range(0, 15) == 0) brightness = 4'($urandom);
      if ($urandom_range(0, 3) == 0 && value[15:8] != 8'h0) value[15:8] = 8'h0;
    end
    load = 1'b0; blank_lz = 1'b0; blink_mask = 4'h0; brightness = 4'hF;
    $display("test_random done");
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_fd(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rmid_sync: got no frame_done expected a pulse"); end
    do_load(16'h5555, 4'hF);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (LED_out !== 7'b1111111) begin n_fail++; $display("FAIL rmid_led: got %b expected 1111111", LED_out); end
    n_checks++;
    if (dp_out !== 1'b1) begin n_fail++; $display("FAIL rmid_dp: got %b expected 1", dp_out); end
    n_checks++;
    if (Anode_Activate !== 4'hF) begin n_fail++; $display("FAIL rmid_anode: got %b expected 1111", Anode_Activate); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (LED_out !== 7'b0000001) begin n_fail++; $display("FAIL rmid_first_led: got %b expected 0000001", LED_out); end
    n_checks++;
    if (Anode_Activate !== 4'b1110) begin n_fail++; $display("FAIL rmid_first_anode: got %b expected 1110", Anode_Activate); end
    wait_fd(ok);
    @(negedge clk);
    n_checks++;
    if (LED_out !== 7'b0000001 || dp_out !== 1'b1) begin
      n_fail++; $display("FAIL rmid_pending_discard: got %b/%b expected 0000001/1", LED_out, dp_out);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_wrap6();
    bit ok;
    int t0;
    wait_fd6(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL wrap6_sync: got no frame_done expected a pulse"); end
    t0 = cyc;
    @(negedge clk);
    n_checks++;
    if (an6 !== 6'b111110) begin n_fail++; $display("FAIL wrap6_d0: got %b expected 111110", an6); end
    repeat (5 * R) @(negedge clk);
    n_checks++;
    if (an6 !== 6'b011111) begin n_fail++; $display("FAIL wrap6_d5: got %b expected 011111", an6); end
    repeat (R - 1) @(negedge clk);
    n_checks++;
    if (fd6 !== 1'b1 || (cyc - t0) != 6 * R) begin
      n_fail++; $display("FAIL wrap6_period: got fd=%b after %0d expected 1 after %0d", fd6, cyc - t0, 6 * R);
    end
    @(negedge clk);
    n_checks++;
    if (an6 !== 6'b111110) begin n_fail++; $display("FAIL wrap6_back0: got %b expected 111110", an6); end
    $display("test_wrap6 done");
  endtask

  initial begin
    test_reset();
    test_decode();
    test_double_load();
    test_load_on_boundary();
    test_lz();
    test_pwm();
    test_blink();
    test_random();
    test_reset_mid();
    test_wrap6();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
